// File: rtl/mbc_pkg.sv
// Shared decode constants, RTC register codes and counter limits for the parameterised MBC.
package mbc_pkg;

    // Register region, selected by cart_addr[14:13]
    localparam logic [1:0] RegRamEn   = 2'b00;
    localparam logic [1:0] RegRomBank = 2'b01;
    localparam logic [1:0] RegRamBank = 2'b10;
    localparam logic [1:0] RegLatch   = 2'b11;
    // With A15 high, region 01 is the cart RAM window A000-BFFF
    localparam logic [1:0] RegCram    = 2'b01;

    localparam logic [7:0] RtcCodeLo = 8'h08;
    localparam logic [7:0] RtcCodeHi = 8'h0C;

    localparam int unsigned MinSecMax = 59;
    localparam int unsigned HourMax   = 23;
    localparam int unsigned DayMax    = 511;

    // Low three bits of codes 08-0C index the RTC registers directly
    typedef enum logic [2:0] {
        RtcSec   = 3'd0,
        RtcMin   = 3'd1,
        RtcHour  = 3'd2,
        RtcDayLo = 3'd3,
        RtcDayHi = 3'd4
    } rtc_reg_e;

    function automatic logic is_rtc_code(input logic [7:0] code);
        return (code >= RtcCodeLo) && (code <= RtcCodeHi);
    endfunction

endpackage

// File: rtl/mbc_rtc.sv
// Real-time clock: live counters, latch sequence and latched read-back.
module mbc_rtc
    import mbc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       wr_i,
    input  rtc_reg_e   reg_i,
    input  logic [7:0] wdata_i,
    input  logic       latch_wr_i,
    output logic [7:0] rdata_o
);

    localparam logic [5:0] MsLim  = 6'(MinSecMax);
    localparam logic [4:0] HrLim  = 5'(HourMax);
    localparam logic [8:0] DayLim = 9'(DayMax);

    logic [5:0] sec_q, sec_d, min_q, min_d, lsec_q, lsec_d, lmin_q, lmin_d;
    logic [4:0] hour_q, hour_d, lhour_q, lhour_d;
    logic [8:0] day_q, day_d, lday_q, lday_d;
    logic       halt_q, halt_d, carry_q, carry_d, lhalt_q, lhalt_d, lcarry_q, lcarry_d;
    logic       arm_q, arm_d;
    logic       c_min, c_hour, c_day;

    always_comb begin
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        day_d    = day_q;
        halt_d   = halt_q;
        carry_d  = carry_q;
        lsec_d   = lsec_q;
        lmin_d   = lmin_q;
        lhour_d  = lhour_q;
        lday_d   = lday_q;
        lhalt_d  = lhalt_q;
        lcarry_d = lcarry_q;
        arm_d    = arm_q;
        c_min    = 1'b0;
        c_hour   = 1'b0;
        c_day    = 1'b0;

        // Out-of-range values run up to the field width and wrap naturally without carry
        if (tick_i && !halt_q) begin
            c_min = (sec_q == MsLim);
            sec_d = c_min ? 6'd0 : sec_q + 6'd1;
            if (c_min) begin
                c_hour = (min_q == MsLim);
                min_d  = c_hour ? 6'd0 : min_q + 6'd1;
            end
            if (c_hour) begin
                c_day  = (hour_q == HrLim);
                hour_d = c_day ? 5'd0 : hour_q + 5'd1;
            end
            if (c_day) begin
                day_d = day_q + 9'd1;
                if (day_q == DayLim) carry_d = 1'b1;
            end
        end

        if (wr_i) begin
            case (reg_i)
                RtcSec:   sec_d        = wdata_i[5:0];
                RtcMin:   min_d        = wdata_i[5:0];
                RtcHour:  hour_d       = wdata_i[4:0];
                RtcDayLo: day_d[7:0]   = wdata_i;
                RtcDayHi: begin
                    day_d[8] = wdata_i[0];
                    halt_d   = wdata_i[6];
                    carry_d  = wdata_i[7];
                end
                default: ;
            endcase
        end

        if (latch_wr_i) begin
            arm_d = (wdata_i == 8'h00);
            if (arm_q && wdata_i == 8'h01) begin
                lsec_d   = sec_q;
                lmin_d   = min_q;
                lhour_d  = hour_q;
                lday_d   = day_q;
                lhalt_d  = halt_q;
                lcarry_d = carry_q;
            end
        end
    end

    always_comb begin
        rdata_o = 8'hFF;
        case (reg_i)
            RtcSec:   rdata_o = {2'b00, lsec_q};
            RtcMin:   rdata_o = {2'b00, lmin_q};
            RtcHour:  rdata_o = {3'b000, lhour_q};
            RtcDayLo: rdata_o = lday_q[7:0];
            RtcDayHi: rdata_o = {lcarry_q, lhalt_q, 5'b00000, lday_q[8]};
            default:  rdata_o = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            day_q    <= '0;
            halt_q   <= 1'b0;
            carry_q  <= 1'b0;
            lsec_q   <= '0;
            lmin_q   <= '0;
            lhour_q  <= '0;
            lday_q   <= '0;
            lhalt_q  <= 1'b0;
            lcarry_q <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            day_q    <= day_d;
            halt_q   <= halt_d;
            carry_q  <= carry_d;
            lsec_q   <= lsec_d;
            lmin_q   <= lmin_d;
            lhour_q  <= lhour_d;
            lday_q   <= lday_d;
            lhalt_q  <= lhalt_d;
            lcarry_q <= lcarry_d;
            arm_q    <= arm_d;
        end
    end

endmodule

// File: rtl/mbc_param.sv
// Parameterised ROM/RAM bank controller with savestate access.
// Optional RTC compiled in with `define MBC_PARAM_RTC_EN.
module mbc_param
    import mbc_pkg::*;
#(
    parameter int unsigned ROM_BANK_W = 9,
    parameter int unsigned RAM_BANK_W = 4,
    parameter int unsigned ZERO_REMAP = 1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce_cpu,
    input  logic                   enable,
    input  logic                   has_ram,
    input  logic [14:0]            cart_addr,
    input  logic                   cart_a15,
    input  logic                   cart_wr,
    input  logic [7:0]             cart_di,
    input  logic [ROM_BANK_W-1:0]  rom_mask,
    input  logic [RAM_BANK_W-1:0]  ram_mask,
    input  logic [7:0]             cram_di,
    output logic [7:0]             cram_do,
    output logic [RAM_BANK_W+12:0] cram_addr,
    output logic                   ram_enabled,
    output logic [ROM_BANK_W+13:0] mbc_addr,
    input  logic                   savestate_load,
    input  logic [15:0]            savestate_data,
    output logic [15:0]            savestate_back,
    input  logic                   rtc_tick
);

    localparam int unsigned SsW = 1 + RAM_BANK_W + ROM_BANK_W;

    logic [ROM_BANK_W-1:0] rom_bank_q, rom_bank_d, eff_bank;
    logic [RAM_BANK_W-1:0] ram_bank_q, ram_bank_d;
    logic                  ram_en_q, ram_en_d;
    logic [15:0]           rom_wide;
    logic                  reg_wr;
    logic                  rtc_sel;
    logic [7:0]            rtc_rdata;

    assign reg_wr = enable & ce_cpu & cart_wr & ~cart_a15;

    always_comb begin
        rom_bank_d = rom_bank_q;
        ram_bank_d = ram_bank_q;
        ram_en_d   = ram_en_q;
        rom_wide   = 16'(rom_bank_q);
        if (reg_wr) begin
            case (cart_addr[14:13])
                RegRamEn:   ram_en_d = (cart_di[3:0] == 4'hA);
                RegRomBank: begin
                    // High-byte writes fall off the top when the bank fits in 8 bits
                    if (!cart_addr[12]) rom_wide[7:0]  = cart_di;
                    else                rom_wide[15:8] = cart_di;
                    rom_bank_d = rom_wide[ROM_BANK_W-1:0];
                end
                RegRamBank: ram_bank_d = cart_di[RAM_BANK_W-1:0];
                default: ;
            endcase
        end
        if (savestate_load) begin
            {ram_en_d, ram_bank_d, rom_bank_d} = savestate_data[0 +: SsW];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rom_bank_q <= ROM_BANK_W'(1);
            ram_bank_q <= '0;
            ram_en_q   <= 1'b0;
        end else begin
            rom_bank_q <= rom_bank_d;
            ram_bank_q <= ram_bank_d;
            ram_en_q   <= ram_en_d;
        end
    end

`ifdef MBC_PARAM_RTC_EN
    logic     rtc_sel_q, rtc_sel_d;
    rtc_reg_e rtc_reg_q, rtc_reg_d;
    logic     rtc_wr, latch_wr;

    always_comb begin
        rtc_sel_d = rtc_sel_q;
        rtc_reg_d = rtc_reg_q;
        if (reg_wr && cart_addr[14:13] == RegRamBank) begin
            rtc_sel_d = is_rtc_code(cart_di);
            if (is_rtc_code(cart_di)) rtc_reg_d = rtc_reg_e'(cart_di[2:0]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rtc_sel_q <= 1'b0;
            rtc_reg_q <= RtcSec;
        end else begin
            rtc_sel_q <= rtc_sel_d;
            rtc_reg_q <= rtc_reg_d;
        end
    end

    assign rtc_sel  = rtc_sel_q;
    assign latch_wr = reg_wr && (cart_addr[14:13] == RegLatch);
    assign rtc_wr   = enable & ce_cpu & cart_wr & cart_a15 & (cart_addr[14:13] == RegCram)
                      & ram_en_q & rtc_sel_q;

    mbc_rtc u_rtc (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .tick_i     (rtc_tick),
        .wr_i       (rtc_wr),
        .reg_i      (rtc_reg_q),
        .wdata_i    (cart_di),
        .latch_wr_i (latch_wr),
        .rdata_o    (rtc_rdata)
    );
`else
    logic unused_rtc;
    assign unused_rtc = rtc_tick;
    assign rtc_sel    = 1'b0;
    assign rtc_rdata  = 8'hFF;
`endif

    if (SsW < 16) begin : g_ss_unused
        logic [15-SsW:0] unused_ss;
        assign unused_ss = savestate_data[15:SsW];
    end

    assign eff_bank = (ZERO_REMAP != 0 && rom_bank_q == '0) ? ROM_BANK_W'(1) : rom_bank_q;

    always_comb begin
        mbc_addr       = '0;
        cram_addr      = '0;
        ram_enabled    = 1'b0;
        cram_do        = 8'hFF;
        savestate_back = '0;
        if (enable) begin
            mbc_addr = cart_addr[14] ? {eff_bank & rom_mask, cart_addr[13:0]}
                                     : {{ROM_BANK_W{1'b0}}, cart_addr[13:0]};
            cram_addr      = {ram_bank_q & ram_mask, cart_addr[12:0]};
            ram_enabled    = ram_en_q & has_ram & ~rtc_sel;
            savestate_back = 16'({ram_en_q, ram_bank_q, rom_bank_q});
            if (ram_en_q & has_ram & ~rtc_sel) cram_do = cram_di;
            else if (ram_en_q & rtc_sel)       cram_do = rtc_rdata;
        end
    end

endmodule
